grf_wport_arb: RTL and testbench

- Arbitrates the single general-register-file write port (A3/WD/WE/PC) between two sources:
  - Primary: the in-order pipeline writeback.
  - Secondary: the multi-cycle MDU/late-load completion path, which holds its result until the port is free.
- Secondary writes go through a small FIFO. A scoreboard reports registers with pending secondary writes so decode can stall.
- A starvation counter forces one pipeline hold cycle when the FIFO head waits too long.

---
 rtl/grf_wport_arb.sv | 142 ++++++++++++++
 tb/tb_grf_wport_arb.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/grf_wport_arb.sv
// rtl/grf_wport_arb.sv - GRF write-port arbiter: in-order writeback vs. queued secondary completions
// Optional: define GRF_WB_TRACE_EN to print every committed register write.
module grf_wport_arb #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        P_WE,
  input  logic [4:0]  P_A3,
  input  logic [31:0] P_WD,
  input  logic [31:0] P_PC,
  input  logic        S_Valid,
  input  logic [4:0]  S_A3,
  input  logic [31:0] S_WD,
  input  logic [31:0] S_PC,
  output logic        S_Ready,
  input  logic [4:0]  Q_A1,
  input  logic [4:0]  Q_A2,
  output logic        Q_Busy,
  output logic        Hold_P,
  output logic        WE,
  output logic [4:0]  A3,
  output logic [31:0] WD,
  output logic [31:0] PC,
  output logic        Conflict
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [SW-1:0] STARVE_C = SW'(STARVE_MAX);

  logic [4:0]       ent_a3 [DEPTH];
  logic [31:0]      ent_wd [DEPTH];
  logic [31:0]      ent_pc [DEPTH];
  logic [DEPTH-1:0] ent_vld;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [SW-1:0]    starve_cnt;
  logic [SW-1:0]    starve_nxt;

  logic pv;
  logic empty;
  logic pop;
  logic push;
  logic p_hit;
  logic q_hit1;
  logic q_hit2;

  assign pv      = P_WE && (P_A3 != 5'd0) && !Hold_P;
  assign empty   = (count == '0);
  assign pop     = !pv && !empty;
  assign S_Ready = (count < DEPTH_C);
  // Writes to $0 are accepted and dropped so the producer never stalls on them.
  assign push    = S_Valid && S_Ready && (S_A3 != 5'd0);

  always_comb begin
    WE = 1'b0;
    A3 = '0;
    WD = '0;
    PC = '0;
    if (pv) begin
      WE = 1'b1;
      A3 = P_A3;
      WD = P_WD;
      PC = P_PC;
    end else if (!empty) begin
      WE = 1'b1;
      A3 = ent_a3[rd_ptr];
      WD = ent_wd[rd_ptr];
      PC = ent_pc[rd_ptr];
    end
  end

  always_comb begin
    p_hit  = 1'b0;
    q_hit1 = 1'b0;
    q_hit2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_vld[i]) begin
        if (ent_a3[i] == P_A3) p_hit  = 1'b1;
        if (ent_a3[i] == Q_A1) q_hit1 = 1'b1;
        if (ent_a3[i] == Q_A2) q_hit2 = 1'b1;
      end
    end
  end

  assign Q_Busy = (q_hit1 && (Q_A1 != 5'd0)) || (q_hit2 && (Q_A2 != 5'd0));

  always_comb begin
    starve_nxt = starve_cnt;
    if (empty || pop) starve_nxt = '0;
    else if (pv)      starve_nxt = starve_cnt + SW'(1);
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      ent_a3[wr_ptr] <= S_A3;
      ent_wd[wr_ptr] <= S_WD;
      ent_pc[wr_ptr] <= S_PC;
    end
  end

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      ent_vld    <= '0;
      starve_cnt <= '0;
      Hold_P     <= 1'b0;
      Conflict   <= 1'b0;
    end else begin
      // A push never lands on the slot being popped: full blocks push, empty blocks pop.
      if (pop) begin
        ent_vld[rd_ptr] <= 1'b0;
        rd_ptr          <= rd_ptr + AW'(1);
      end
      if (push) begin
        ent_vld[wr_ptr] <= 1'b1;
        wr_ptr          <= wr_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      starve_cnt <= starve_nxt;
      Hold_P     <= (starve_nxt == STARVE_C);
      Conflict   <= Conflict | (pv && p_hit);
    end
  end

`ifdef GRF_WB_TRACE_EN
  always_ff @(posedge CLK) begin
    if (WE) $display("%d@%h: $%d <= %h", $time, PC, A3, WD);
  end
`endif

endmodule

// File: tb/tb_grf_wport_arb.sv
// tb/tb_grf_wport_arb.sv - directed bench for grf_wport_arb with a queue-based reference model
module tb_grf_wport_arb;
  localparam int DEPTH      = 4;
  localparam int STARVE_MAX = 8;

  logic        CLK;
  logic        Reset;
  logic        P_WE;
  logic [4:0]  P_A3;
  logic [31:0] P_WD;
  logic [31:0] P_PC;
  logic        S_Valid;
  logic [4:0]  S_A3;
  logic [31:0] S_WD;
  logic [31:0] S_PC;
  logic        S_Ready;
  logic [4:0]  Q_A1;
  logic [4:0]  Q_A2;
  logic        Q_Busy;
  logic        Hold_P;
  logic        WE;
  logic [4:0]  A3;
  logic [31:0] WD;
  logic [31:0] PC;
  logic        Conflict;

  grf_wport_arb #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .CLK(CLK), .Reset(Reset),
    .P_WE(P_WE), .P_A3(P_A3), .P_WD(P_WD), .P_PC(P_PC),
    .S_Valid(S_Valid), .S_A3(S_A3), .S_WD(S_WD), .S_PC(S_PC), .S_Ready(S_Ready),
    .Q_A1(Q_A1), .Q_A2(Q_A2), .Q_Busy(Q_Busy), .Hold_P(Hold_P),
    .WE(WE), .A3(A3), .WD(WD), .PC(PC), .Conflict(Conflict)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: pending secondary writes as an ordered queue.
  typedef struct packed {
    logic [4:0]  a3;
    logic [31:0] wd;
    logic [31:0] pc;
  } ent_t;

  ent_t mq[$];
  int   m_streak = 0;
  bit   m_hold   = 0;
  bit   m_conf   = 0;
  bit   cmp_en   = 0;

  function automatic bit in_q(input logic [4:0] r);
    foreach (mq[i]) if (mq[i].a3 == r) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge CLK) begin
    bit   pv;
    bit   popped;
    int   n;
    ent_t e;
    if (!Reset) begin
      mq.delete();
      m_streak = 0;
      m_hold   = 0;
      m_conf   = 0;
    end else begin
      pv = P_WE && (P_A3 != 0) && !m_hold;
      n  = mq.size();
      if (pv && in_q(P_A3)) m_conf = 1;
      popped = !pv && (n > 0);
      if (popped) void'(mq.pop_front());
      if (S_Valid && (n < DEPTH) && (S_A3 != 0)) begin
        e.a3 = S_A3; e.wd = S_WD; e.pc = S_PC;
        mq.push_back(e);
      end
      if (n == 0 || popped) m_streak = 0;
      else                  m_streak = m_streak + 1;
      m_hold = (m_streak == STARVE_MAX);
    end
    cmp_en = 1;
  end

  always @(negedge CLK) begin
    bit          pv;
    logic        e_we;
    logic [4:0]  e_a3;
    logic [31:0] e_wd;
    logic [31:0] e_pc;
    if (cmp_en) begin
      pv = P_WE && (P_A3 != 0) && !m_hold;
      e_we = 0; e_a3 = 0; e_wd = 0; e_pc = 0;
      if (pv) begin
        e_we = 1; e_a3 = P_A3; e_wd = P_WD; e_pc = P_PC;
      end else if (mq.size() > 0) begin
        e_we = 1; e_a3 = mq[0].a3; e_wd = mq[0].wd; e_pc = mq[0].pc;
      end
      chk("m_we", WE, e_we);
      chk("m_a3", A3, e_a3);
      chk("m_wd", WD, e_wd);
      chk("m_pc", PC, e_pc);
      chk("m_sready", S_Ready, mq.size() < DEPTH);
      chk("m_qbusy", Q_Busy, ((Q_A1 != 0) && in_q(Q_A1)) || ((Q_A2 != 0) && in_q(Q_A2)));
      chk("m_hold", Hold_P, m_hold);
      chk("m_conflict", Conflict, m_conf);
    end
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic at_neg;
    @(negedge CLK);
  endtask

  initial begin
    Reset = 0; P_WE = 0; P_A3 = 0; P_WD = 0; P_PC = 0;
    S_Valid = 0; S_A3 = 0; S_WD = 0; S_PC = 0; Q_A1 = 0; Q_A2 = 0;

    // Reset held two cycles with a pending secondary request.
    S_Valid = 1; S_A3 = 5'd3; S_WD = 32'h33; Q_A1 = 5'd3;
    tick;
    at_neg;
    chk("rst_sready", S_Ready, 1'b1);
    chk("rst_qbusy", Q_Busy, 1'b0);
    tick;
    Reset = 1; S_Valid = 0;
    at_neg;
    chk("post_rst_we", WE, 1'b0);
    chk("post_rst_qbusy", Q_Busy, 1'b0);
    chk("post_rst_hold", Hold_P, 1'b0);
    tick;

    // Idle port: one-cycle secondary latency.
    S_Valid = 1; S_A3 = 5'd5; S_WD = 32'h1234; S_PC = 32'h100; Q_A1 = 5'd5;
    at_neg;
    chk("lat_we_pre", WE, 1'b0);
    chk("lat_busy_pre", Q_Busy, 1'b0);
    tick;
    S_Valid = 0;
    at_neg;
    chk("lat_we", WE, 1'b1);
    chk("lat_a3", A3, 32'd5);
    chk("lat_wd", WD, 32'h1234);
    chk("lat_busy", Q_Busy, 1'b1);
    tick;
    at_neg;
    chk("lat_we_post", WE, 1'b0);
    chk("lat_busy_post", Q_Busy, 1'b0);
    tick;

    // Starvation: primary writes $8 every cycle, fill the FIFO.
    P_WE = 1; P_A3 = 5'd8; P_WD = 32'h8888; P_PC = 32'h200; Q_A1 = 0;
    for (int k = 0; k < 5; k++) begin
      S_Valid = 1; S_A3 = 5'(k + 1); S_WD = 32'hA0 + 32'(k); S_PC = 32'h300 + 32'(k);
      at_neg;
      chk("fill_sready", S_Ready, (k == 4) ? 1'b0 : 1'b1);
      chk("fill_a3", A3, 32'd8);
      chk("fill_hold", Hold_P, 1'b0);
      tick;
    end
    S_Valid = 0;
    for (int k = 5; k < 9; k++) begin
      at_neg;
      chk("starve_hold_lo", Hold_P, 1'b0);
      tick;
    end
    at_neg;
    chk("starve_hold_hi", Hold_P, 1'b1);
    chk("starve_we", WE, 1'b1);
    chk("starve_a3", A3, 32'd1);
    chk("starve_wd", WD, 32'hA0);
    tick;
    at_neg;
    chk("starve_hold_end", Hold_P, 1'b0);
    chk("starve_a3_prim", A3, 32'd8);
    tick;
    P_WE = 0;
    repeat (4) tick;

    // Same register twice: commits in order, busy until the second pop.
    Q_A1 = 5'd9; S_Valid = 1; S_A3 = 5'd9; S_WD = 32'hAAAA;
    at_neg;
    chk("ord_we0", WE, 1'b0);
    tick;
    S_WD = 32'hBBBB;
    at_neg;
    chk("ord_a3_1", A3, 32'd9);
    chk("ord_wd_1", WD, 32'hAAAA);
    chk("ord_busy_1", Q_Busy, 1'b1);
    tick;
    S_Valid = 0;
    at_neg;
    chk("ord_wd_2", WD, 32'hBBBB);
    chk("ord_busy_2", Q_Busy, 1'b1);
    tick;
    at_neg;
    chk("ord_busy_3", Q_Busy, 1'b0);
    chk("ord_we_3", WE, 1'b0);
    tick;

    // Conflict: primary hits a pending $6.
    Q_A1 = 0; P_WE = 1; P_A3 = 5'd7; P_WD = 32'h7777;
    S_Valid = 1; S_A3 = 5'd6; S_WD = 32'h6666;
    at_neg;
    chk("conf_pre", Conflict, 1'b0);
    tick;
    S_Valid = 0; P_A3 = 5'd6; P_WD = 32'h6006;
    at_neg;
    chk("conf_prim_we", WE, 1'b1);
    chk("conf_prim_a3", A3, 32'd6);
    chk("conf_prim_wd", WD, 32'h6006);
    chk("conf_not_yet", Conflict, 1'b0);
    tick;
    P_WE = 0;
    at_neg;
    chk("conf_set", Conflict, 1'b1);
    chk("conf_head_wd", WD, 32'h6666);
    tick;
    S_Valid = 1; S_A3 = 5'd10; P_WE = 1; P_A3 = 5'd12;
    at_neg;
    chk("conf_sticky", Conflict, 1'b1);
    tick;
    S_Valid = 0; Reset = 0; Q_A1 = 5'd10;
    at_neg;
    chk("mid_rst_busy", Q_Busy, 1'b1);
    tick;
    Reset = 1; P_WE = 0;
    at_neg;
    chk("conf_cleared", Conflict, 1'b0);
    chk("mid_rst_we", WE, 1'b0);
    chk("mid_rst_qbusy", Q_Busy, 1'b0);
    tick;

    // Register-0 traffic is invisible.
    Q_A1 = 0; S_Valid = 1; S_A3 = 0; S_WD = 32'hDEAD; P_WE = 1; P_A3 = 0; P_WD = 32'hBEEF;
    at_neg;
    chk("zero_we", WE, 1'b0);
    tick;
    S_Valid = 0; P_WE = 0;
    at_neg;
    chk("zero_we_next", WE, 1'b0);
    chk("zero_sready", S_Ready, 1'b1);
    chk("zero_conflict", Conflict, 1'b0);
    tick;

    // Mixed traffic, checked by the model every cycle.
    for (int i = 0; i < 60; i++) begin
      P_WE = (i % 3) != 0; P_A3 = 5'(i % 7); P_WD = 32'h1000 + 32'(i); P_PC = 32'h4000 + 32'(i);
      S_Valid = (i % 2) == 0; S_A3 = 5'((i * 3) % 5); S_WD = 32'h2000 + 32'(i); S_PC = 32'h5000 + 32'(i);
      Q_A1 = 5'(i % 5); Q_A2 = 5'((i + 2) % 5);
      tick;
    end
    P_WE = 0; S_Valid = 0;
    repeat (8) tick;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
